cdb_arbiter: RTL and testbench

//   Shares the single common data bus (CDB) between the adder, multiplier and branch functional units.

---
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Each of the ADD, MUL and BRANCH units hands a finished result to its own
// holding register. One pending result per cycle is granted round-robin and
// broadcast on a registered CDB that every reservation station snoops.
// A flush drops every result that has not been broadcast yet.
module cdb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_SRC-1:0]          req_valid,
  input  logic [N_SRC*TAG_W-1:0]    req_tag,
  input  logic [N_SRC*DATA_W-1:0]   req_value,
  output logic [N_SRC-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [1:0]                cdb_src,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [N_SRC-1:0]          pend
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;

  logic [TAG_W-1:0]  hold_tag_q [N_SRC];
  logic [TAG_W-1:0]  hold_tag_d [N_SRC];
  logic [DATA_W-1:0] hold_val_q [N_SRC];
  logic [DATA_W-1:0] hold_val_d [N_SRC];

  logic [N_SRC-1:0]  grant_rr;
  logic [N_SRC-1:0]  grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [N_SRC-1:0]  accept;

  // Round-robin search over occupied holding registers, starting at rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    grant_rr = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    for (int off = 0; off < N_SRC; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!gnt_any && pend_q[idx]) begin
        gnt_any       = 1'b1;
        gnt_idx       = PTR_W'(idx);
        grant_rr[idx] = 1'b1;
      end
    end
  end

  // Flush blocks both granting and accepting for that cycle; a granted
  // source may refill in the same cycle so each unit sustains one per cycle.
  always_comb begin
    grant     = flush ? '0 : grant_rr;
    req_ready = flush ? '0 : (~pend_q | grant);
    accept    = req_valid & req_ready;
  end

  // Next-state for occupancy, holding registers, round-robin pointer and CDB.
  always_comb begin
    pend_d      = (pend_q & ~grant) | accept;
    hold_tag_d  = hold_tag_q;
    hold_val_d  = hold_val_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_src_d   = cdb_src_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;

    for (int i = 0; i < N_SRC; i++) begin
      if (accept[i]) begin
        hold_tag_d[i] = req_tag[i*TAG_W +: TAG_W];
        hold_val_d[i] = req_value[i*DATA_W +: DATA_W];
      end
    end

    if (flush) begin
      pend_d   = '0;
      rr_ptr_d = '0;
    end else if (gnt_any) begin
      // The broadcast takes the old hold contents even if a refill lands now.
      cdb_valid_d = 1'b1;
      cdb_src_d   = 2'(gnt_idx);
      cdb_tag_d   = hold_tag_q[gnt_idx];
      cdb_value_d = hold_val_q[gnt_idx];
      rr_ptr_d    = (gnt_idx == PTR_W'(N_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // Control and broadcast state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= '0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  // Holding registers are plain data; pend qualifies their contents.
  always_ff @(posedge clk) begin
    hold_tag_q <= hold_tag_d;
    hold_val_q <= hold_val_d;
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_src   = cdb_src_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for the CDB arbiter.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  req_valid;
  logic [8:0]  req_tag;
  logic [95:0] req_value;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [1:0]  cdb_src;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [2:0]  pend;

  int checks;
  int errors;

  cdb_arbiter #(.N_SRC(3), .TAG_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_src(cdb_src),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [2:0]  vld;
    logic [8:0]  tag;
    logic [95:0] val;
    logic [2:0]  rdy;
    logic        cv;
    logic [1:0]  cs;
    logic [2:0]  ct;
    logic [31:0] cval;
    logic [2:0]  pend;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic fl, input logic [2:0] vld,
                              input logic [2:0] t2, input logic [2:0] t1, input logic [2:0] t0,
                              input int v2, input int v1, input int v0,
                              input logic [2:0] rdy, input logic cv, input logic [1:0] cs,
                              input logic [2:0] ct, input int cval, input logic [2:0] pd);
    vec_t v;
    v.flush = fl;
    v.vld   = vld;
    v.tag   = {t2, t1, t0};
    v.val   = {32'(v2), 32'(v1), 32'(v0)};
    v.rdy   = rdy;
    v.cv    = cv;
    v.cs    = cs;
    v.ct    = ct;
    v.cval  = 32'(cval);
    v.pend  = pd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one row at the falling edge, check ready before the rising edge,
  // then check the registered outputs just after it.
  task automatic run_row(input vec_t v, input int n);
    @(negedge clk);
    flush     = v.flush;
    req_valid = v.vld;
    req_tag   = v.tag;
    req_value = v.val;
    #1;
    chk($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("row%0d cdb_valid", n), 32'(cdb_valid), 32'(v.cv));
    chk($sformatf("row%0d cdb_src", n),   32'(cdb_src),   32'(v.cs));
    chk($sformatf("row%0d cdb_tag", n),   32'(cdb_tag),   32'(v.ct));
    chk($sformatf("row%0d cdb_value", n), cdb_value,      v.cval);
    chk($sformatf("row%0d pend", n),      32'(pend),      32'(v.pend));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_value = '0;

    // fl vld  t2 t1 t0  v2 v1 v0  rdy cv cs ct cval pend
    vecs[0]  = mk(0, 3'b111, 3'b110, 3'b101, 3'b001, 300, 200, 100, 3'b111, 0, 0, 3'b000, 0,   3'b111);
    vecs[1]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b001, 1, 0, 3'b001, 100, 3'b110);
    vecs[2]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b011, 1, 1, 3'b101, 200, 3'b100);
    vecs[3]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b111, 1, 2, 3'b110, 300, 3'b000);
    vecs[4]  = mk(0, 3'b001, 0, 0, 3'b010, 0, 0, 7,                 3'b111, 0, 2, 3'b110, 300, 3'b001);
    vecs[5]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b111, 1, 0, 3'b010, 7,   3'b000);
    vecs[6]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b111, 0, 0, 3'b010, 7,   3'b000);
    vecs[7]  = mk(0, 3'b010, 0, 3'b100, 0, 0, 10, 0,                3'b111, 0, 0, 3'b010, 7,   3'b010);
    vecs[8]  = mk(0, 3'b010, 0, 3'b101, 0, 0, 11, 0,                3'b111, 1, 1, 3'b100, 10,  3'b010);
    vecs[9]  = mk(0, 3'b010, 0, 3'b111, 0, 0, 12, 0,                3'b111, 1, 1, 3'b101, 11,  3'b010);
    vecs[10] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b111, 1, 1, 3'b111, 12,  3'b000);
    vecs[11] = mk(0, 3'b011, 0, 3'b001, 3'b000, 0, 60, 50,          3'b111, 0, 1, 3'b111, 12,  3'b011);
    vecs[12] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b101, 1, 0, 3'b000, 50,  3'b010);
    vecs[13] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b111, 1, 1, 3'b001, 60,  3'b000);
    vecs[14] = mk(0, 3'b110, 3'b011, 3'b010, 0, 80, 70, 0,          3'b111, 0, 1, 3'b001, 60,  3'b110);
    vecs[15] = mk(1, 3'b001, 0, 0, 3'b111, 0, 0, 99,                3'b000, 0, 1, 3'b001, 60,  3'b000);
    vecs[16] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b111, 0, 1, 3'b001, 60,  3'b000);
    vecs[17] = mk(0, 3'b101, 3'b101, 0, 3'b110, 2, 0, 1,            3'b111, 0, 1, 3'b001, 60,  3'b101);
    vecs[18] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b011, 1, 0, 3'b110, 1,   3'b100);
    vecs[19] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                      3'b111, 1, 2, 3'b101, 2,   3'b000);

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset cdb_valid", 32'(cdb_valid), 32'd0);
    chk("reset pend",      32'(pend),      32'd0);
    chk("reset cdb_src",   32'(cdb_src),   32'd0);
    chk("reset cdb_tag",   32'(cdb_tag),   32'd0);
    chk("reset cdb_value", cdb_value,      32'd0);
    chk("reset req_ready", 32'(req_ready), 32'b111);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) run_row(vecs[i], i);

    // Reset in the middle of a contention burst: results are dropped at once.
    @(negedge clk);
    req_valid = 3'b111;
    req_tag   = {3'b011, 3'b010, 3'b001};
    req_value = {32'd33, 32'd22, 32'd11};
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    #1;
    chk("midrst pre cdb_valid", 32'(cdb_valid), 32'd1);
    chk("midrst pre cdb_value", cdb_value,      32'd11);
    chk("midrst pre pend",      32'(pend),      32'b110);
    #2 rst = 1'b1;
    #1;
    chk("midrst cdb_valid", 32'(cdb_valid), 32'd0);
    chk("midrst pend",      32'(pend),      32'd0);
    chk("midrst cdb_tag",   32'(cdb_tag),   32'd0);
    chk("midrst cdb_value", cdb_value,      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst req_ready", 32'(req_ready), 32'b111);
    @(posedge clk);
    #1;
    chk("postrst cdb_valid", 32'(cdb_valid), 32'd0);
    chk("postrst pend",      32'(pend),      32'd0);
    @(posedge clk);
    #1;
    chk("postrst2 cdb_valid", 32'(cdb_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
